// File: rtl/data_mem_responder_pkg.sv
// Shared address map, STATUS layout and MMIO decode for the CPU data-memory responder.
package data_mem_responder_pkg;

   localparam logic [31:0] MMIO_BASE   = 32'h2000_0000;
   localparam logic [31:0] LED_OFF     = 32'h0000_0000;
   localparam logic [31:0] TXDATA_OFF  = 32'h0000_0004;
   localparam logic [31:0] STATUS_OFF  = 32'h0000_0008;
   localparam logic [31:0] RXDATA_OFF  = 32'h0000_000C;
   localparam logic [31:0] CYCLES_OFF  = 32'h0000_0010;

   localparam int unsigned STATUS_TX_FULL     = 0;
   localparam int unsigned STATUS_TX_EMPTY    = 1;
   localparam int unsigned STATUS_RX_HELD     = 2;
   localparam int unsigned STATUS_TX_OVERFLOW = 3;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_LED,
      REG_TXDATA,
      REG_STATUS,
      REG_RXDATA,
      REG_CYCLES
   } mmio_reg_e;

   // Takes the word address so the ignored byte-offset bits never reach the decode.
   function automatic mmio_reg_e mmio_decode(input logic [29:0] word_addr);
      logic [31:0] byte_addr;
      byte_addr = {word_addr, 2'b00};
      case (byte_addr)
         MMIO_BASE + LED_OFF:    return REG_LED;
         MMIO_BASE + TXDATA_OFF: return REG_TXDATA;
         MMIO_BASE + STATUS_OFF: return REG_STATUS;
         MMIO_BASE + RXDATA_OFF: return REG_RXDATA;
         MMIO_BASE + CYCLES_OFF: return REG_CYCLES;
         default:                return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; a push while full is accepted only alongside a pop.
module byte_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic       full,
   output logic       empty,
   output logic [7:0] head
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW:0] wr_ptr_q, rd_ptr_q;
   logic [7:0]  mem_q [DEPTH];
   logic        do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? 8'h00 : mem_q[rd_ptr_q[PW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data port: word RAM plus LED / TX FIFO / RX holding / cycle-counter MMIO window.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned WORDS    = 1024,
   parameter int unsigned TX_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_mem_addr,
   input  logic [31:0] data_mem_WrData,
   input  logic        data_mem_memwrite,
   input  logic        data_mem_memread,
   output logic [31:0] data_mem_out,
   output logic [7:0]  led,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int unsigned AW = $clog2(WORDS);

   logic [31:0]   ram_q [WORDS];
   logic          ram_hit;
   logic [AW-1:0] ram_idx;
   mmio_reg_e     sel;

   logic [7:0]  led_q;
   logic        rx_held_q, rx_held_d;
   logic [7:0]  rx_byte_q;
   logic        ovf_q, ovf_d;
   logic [31:0] cycles_q;
   logic [31:0] status;

   logic tx_full, tx_empty, tx_push, tx_pop, ovf_event;
   logic status_rd, rx_rd, rx_capture;
   logic unused_addr_bits;

   assign unused_addr_bits = ^data_mem_addr[1:0];

   assign ram_hit = (data_mem_addr[31:AW+2] == '0);
   assign ram_idx = data_mem_addr[AW+1:2];
   assign sel     = ram_hit ? REG_NONE : mmio_decode(data_mem_addr[31:2]);

   assign tx_push    = data_mem_memwrite && (sel == REG_TXDATA);
   assign tx_valid   = !tx_empty;
   assign tx_pop     = tx_valid && tx_ready;
   assign ovf_event  = tx_push && tx_full && !tx_pop;
   assign status_rd  = data_mem_memread && (sel == REG_STATUS);
   assign rx_rd      = data_mem_memread && (sel == REG_RXDATA);
   assign rx_ready   = !rx_held_q;
   assign rx_capture = rx_valid && rx_ready;
   assign led        = led_q;

   byte_fifo #(
      .DEPTH(TX_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (data_mem_WrData[7:0]),
      .full  (tx_full),
      .empty (tx_empty),
      .head  (tx_data)
   );

   always_comb begin
      status = '0;
      status[STATUS_TX_FULL]     = tx_full;
      status[STATUS_TX_EMPTY]    = tx_empty;
      status[STATUS_RX_HELD]     = rx_held_q;
      status[STATUS_TX_OVERFLOW] = ovf_q;
   end

   always_comb begin
      data_mem_out = '0;
      if (data_mem_memread) begin
         if (ram_hit) begin
            data_mem_out = ram_q[ram_idx];
         end else begin
            case (sel)
               REG_LED:    data_mem_out = {24'h0, led_q};
               REG_STATUS: data_mem_out = status;
               REG_RXDATA: data_mem_out = rx_held_q ? {24'h0, rx_byte_q} : 32'h0;
               REG_CYCLES: data_mem_out = cycles_q;
               default:    data_mem_out = '0;
            endcase
         end
      end
   end

   // A capture can only happen with rx_held clear, so it never races the read-clear.
   always_comb begin
      rx_held_d = rx_held_q;
      if (rx_capture)  rx_held_d = 1'b1;
      else if (rx_rd)  rx_held_d = 1'b0;
      ovf_d = ovf_q;
      if (ovf_event)      ovf_d = 1'b1;
      else if (status_rd) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (data_mem_memwrite && ram_hit) ram_q[ram_idx] <= data_mem_WrData;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q     <= '0;
         rx_held_q <= 1'b0;
         rx_byte_q <= '0;
         ovf_q     <= 1'b0;
         cycles_q  <= '0;
      end else begin
         if (data_mem_memwrite && (sel == REG_LED)) led_q <= data_mem_WrData[7:0];
         if (rx_capture) rx_byte_q <= rx_data;
         rx_held_q <= rx_held_d;
         ovf_q     <= ovf_d;
         cycles_q  <= cycles_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder; inputs change on the falling edge.
module tb_data_mem_responder;

   localparam logic [31:0] A_LED    = 32'h2000_0000;
   localparam logic [31:0] A_TXDATA = 32'h2000_0004;
   localparam logic [31:0] A_STATUS = 32'h2000_0008;
   localparam logic [31:0] A_RXDATA = 32'h2000_000C;
   localparam logic [31:0] A_CYCLES = 32'h2000_0010;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] data_mem_addr;
   logic [31:0] data_mem_WrData;
   logic        data_mem_memwrite;
   logic        data_mem_memread;
   logic [31:0] data_mem_out;
   logic [7:0]  led;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .WORDS    (1024),
      .TX_DEPTH (4)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .data_mem_addr     (data_mem_addr),
      .data_mem_WrData   (data_mem_WrData),
      .data_mem_memwrite (data_mem_memwrite),
      .data_mem_memread  (data_mem_memread),
      .data_mem_out      (data_mem_out),
      .led               (led),
      .tx_data           (tx_data),
      .tx_valid          (tx_valid),
      .tx_ready          (tx_ready),
      .rx_data           (rx_data),
      .rx_valid          (rx_valid),
      .rx_ready          (rx_ready)
   );

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      data_mem_addr     = a;
      data_mem_WrData   = d;
      data_mem_memwrite = 1'b1;
      @(negedge clk);
      data_mem_memwrite = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, output logic [31:0] d);
      data_mem_addr    = a;
      data_mem_memread = 1'b1;
      #1 d = data_mem_out;
      @(negedge clk);
      data_mem_memread = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total_cnt++;
      if (led !== 8'h00) $display("FAIL reset_led: got %h expected 00", led);
      else pass_cnt++;
      total_cnt++;
      if ({tx_valid, tx_data} !== 9'h000)
         $display("FAIL reset_tx: got valid=%b data=%h expected 0/00", tx_valid, tx_data);
      else pass_cnt++;
      total_cnt++;
      if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b expected 1", rx_ready);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_cycles();
      logic [31:0] d;
      repeat (10) @(negedge clk);
      load(A_CYCLES, d);
      total_cnt++;
      if (d !== 32'd10) $display("FAIL cycles_count: got %h expected 0000000a", d);
      else pass_cnt++;
      force dut.cycles_q = 32'hFFFF_FFFF;
      data_mem_addr    = A_CYCLES;
      data_mem_memread = 1'b1;
      #1;
      total_cnt++;
      if (data_mem_out !== 32'hFFFF_FFFF)
         $display("FAIL cycles_forced: got %h expected ffffffff", data_mem_out);
      else pass_cnt++;
      release dut.cycles_q;
      data_mem_memread = 1'b0;
      @(negedge clk);
      load(A_CYCLES, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL cycles_wrap: got %h expected 00000000", d);
      else pass_cnt++;
   endtask

   task automatic test_ram();
      logic [31:0] d;
      store(32'h0000_0010, 32'hDEAD_BEEF);
      load(32'h0000_0010, d);
      total_cnt++;
      if (d !== 32'hDEAD_BEEF) $display("FAIL ram_rw: got %h expected deadbeef", d);
      else pass_cnt++;
      load(32'h0000_1000, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL ram_oob_load: got %h expected 00000000", d);
      else pass_cnt++;
      store(32'h0000_1010, 32'h1111_1111);
      load(32'h0000_0010, d);
      total_cnt++;
      if (d !== 32'hDEAD_BEEF) $display("FAIL ram_oob_store: got %h expected deadbeef", d);
      else pass_cnt++;
      // Same-cycle load and store to one word must return the old value.
      data_mem_addr     = 32'h0000_0010;
      data_mem_WrData   = 32'hCAFE_F00D;
      data_mem_memwrite = 1'b1;
      data_mem_memread  = 1'b1;
      #1;
      total_cnt++;
      if (data_mem_out !== 32'hDEAD_BEEF)
         $display("FAIL ram_rw_same_cycle: got %h expected deadbeef", data_mem_out);
      else pass_cnt++;
      @(negedge clk);
      data_mem_memwrite = 1'b0;
      data_mem_memread  = 1'b0;
      #1;
      total_cnt++;
      if (data_mem_out !== 32'h0) $display("FAIL out_idle: got %h expected 00000000", data_mem_out);
      else pass_cnt++;
      @(negedge clk);
      load(32'h0000_0010, d);
      total_cnt++;
      if (d !== 32'hCAFE_F00D) $display("FAIL ram_after_rw: got %h expected cafef00d", d);
      else pass_cnt++;
   endtask

   task automatic test_led();
      logic [31:0] d;
      store(A_LED, 32'h0000_00A5);
      total_cnt++;
      if (led !== 8'hA5) $display("FAIL led_write: got %h expected a5", led);
      else pass_cnt++;
      load(A_LED, d);
      total_cnt++;
      if (d !== 32'h0000_00A5) $display("FAIL led_read: got %h expected 000000a5", d);
      else pass_cnt++;
      store(32'h2000_0014, 32'hFFFF_FFFF);
      load(32'h2000_0014, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL mmio_unmapped: got %h expected 00000000", d);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (led !== 8'h00) $display("FAIL led_async_reset: got %h expected 00", led);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_tx_overflow();
      logic [31:0] d;
      tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) store(A_TXDATA, 32'(i));
      load(A_STATUS, d);
      total_cnt++;
      if (d !== 32'h9) $display("FAIL tx_status_ovf: got %h expected 00000009", d);
      else pass_cnt++;
      load(A_STATUS, d);
      total_cnt++;
      if (d !== 32'h1) $display("FAIL tx_status_cleared: got %h expected 00000001", d);
      else pass_cnt++;
      tx_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         total_cnt++;
         if (!tx_valid || tx_data !== 8'(i))
            $display("FAIL tx_drain_%0d: got valid=%b data=%h expected 1/%h", i, tx_valid, tx_data,
                     8'(i));
         else pass_cnt++;
         @(negedge clk);
      end
      tx_ready = 1'b0;
      total_cnt++;
      if (tx_valid !== 1'b0) $display("FAIL tx_drained: got valid=%b expected 0", tx_valid);
      else pass_cnt++;
   endtask

   task automatic test_push_pop_full();
      logic [31:0] d;
      logic [7:0]  exp [4];
      exp[0] = 8'h02;
      exp[1] = 8'h03;
      exp[2] = 8'h04;
      exp[3] = 8'h77;
      tx_ready = 1'b0;
      for (int i = 1; i <= 4; i++) store(A_TXDATA, 32'(i));
      tx_ready = 1'b1;
      store(A_TXDATA, 32'h77);
      tx_ready = 1'b0;
      load(A_STATUS, d);
      total_cnt++;
      if (d !== 32'h1) $display("FAIL txpp_status: got %h expected 00000001", d);
      else pass_cnt++;
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total_cnt++;
         if (!tx_valid || tx_data !== exp[i])
            $display("FAIL txpp_order_%0d: got valid=%b data=%h expected 1/%h", i, tx_valid,
                     tx_data, exp[i]);
         else pass_cnt++;
         @(negedge clk);
      end
      tx_ready = 1'b0;
      total_cnt++;
      if (tx_valid !== 1'b0) $display("FAIL txpp_drained: got valid=%b expected 0", tx_valid);
      else pass_cnt++;
   endtask

   task automatic test_rx();
      logic [31:0] d;
      rx_data  = 8'h3C;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'hEE;
      total_cnt++;
      if (rx_ready !== 1'b0) $display("FAIL rx_ready_held: got %b expected 0", rx_ready);
      else pass_cnt++;
      load(A_STATUS, d);
      total_cnt++;
      if (d !== 32'h6) $display("FAIL rx_status: got %h expected 00000006", d);
      else pass_cnt++;
      load(A_RXDATA, d);
      total_cnt++;
      if (d !== 32'h3C) $display("FAIL rx_read: got %h expected 0000003c", d);
      else pass_cnt++;
      total_cnt++;
      if (rx_ready !== 1'b1) $display("FAIL rx_ready_after_read: got %b expected 1", rx_ready);
      else pass_cnt++;
      load(A_RXDATA, d);
      total_cnt++;
      if (d !== 32'h0) $display("FAIL rx_read_empty: got %h expected 00000000", d);
      else pass_cnt++;
      // Read of a held byte racing a new arrival: cleared now, new byte taken next edge.
      rx_data  = 8'h5A;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_data = 8'hC3;
      load(A_RXDATA, d);
      total_cnt++;
      if (d !== 32'h5A) $display("FAIL rx_race_read: got %h expected 0000005a", d);
      else pass_cnt++;
      total_cnt++;
      if (rx_ready !== 1'b1) $display("FAIL rx_race_ready: got %b expected 1", rx_ready);
      else pass_cnt++;
      @(negedge clk);
      rx_valid = 1'b0;
      load(A_RXDATA, d);
      total_cnt++;
      if (d !== 32'hC3) $display("FAIL rx_race_capture: got %h expected 000000c3", d);
      else pass_cnt++;
   endtask

   initial begin
      rst_n             = 1'b0;
      data_mem_addr     = '0;
      data_mem_WrData   = '0;
      data_mem_memwrite = 1'b0;
      data_mem_memread  = 1'b0;
      tx_ready          = 1'b0;
      rx_data           = '0;
      rx_valid          = 1'b0;
      @(negedge clk);
      test_reset();
      test_cycles();
      test_ram();
      test_led();
      test_tx_overflow();
      test_push_pop_full();
      test_rx();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder side of the CPU data-memory port: serves the pipeline's MEM-stage loads and stores from on-chip word RAM and a small memory-mapped I/O window (LED register, byte TX FIFO to host, single-byte RX holding register, free-running cycle counter). It sits directly on the CPU's `data_mem_*` signals at the top level, and its byte streams connect to the host-link UART.

## Interface
- `WORDS`, 1024: RAM depth in 32-bit words. Power of two.
- `TX_DEPTH`, 4: TX FIFO depth in bytes. Power of two, at least 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_mem_addr`  in  32  byte address from the CPU; `[1:0]` ignored, word accesses only.
- `data_mem_WrData`  in  32  store data.
- `data_mem_memwrite`  in  1  store strobe, one cycle per store.
- `data_mem_memread`  in  1  load strobe, one cycle per load.
- `data_mem_out`  out  32  load data, combinational in the same cycle.
- `led`  out  8  LED register.
- `tx_data`  out  8  head byte of the TX FIFO.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  host link accepts `tx_data`.
- `rx_data`  in  8  byte from the host link.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  RX holding register empty.

## Operation
- Address map:
  - RAM: `0x0000_0000` to `WORDS*4-1`. Out-of-range non-MMIO loads return 0. Out-of-range stores are dropped.
  - `0x2000_0000` LED: read/write, bits `[7:0]`.
  - `0x2000_0004` TXDATA: a write pushes `WrData[7:0]`; reads return 0.
  - `0x2000_0008` STATUS, read-only:
    - bit0: tx_full.
    - bit1: tx_empty.
    - bit2: rx_held.
    - bit3: tx_overflow, sticky.
  - `0x2000_000C` RXDATA: a read returns `{24'b0, held byte}` and clears rx_held. When rx_held=0 it returns 0 with no side effect.
  - `0x2000_0010` CYCLES: read-only 32-bit counter that increments every cycle and wraps `0xFFFF_FFFF` to 0.
  - Any other MMIO address reads 0 and ignores writes.
- `data_mem_out` is 0 whenever `data_mem_memread`=0. Read side effects (RX clear, overflow clear) occur only on an edge where `memread`=1.
- Stores commit at the rising edge. With `memread` and `memwrite` both high to the same address, the load returns the pre-write value.
- TX FIFO:
  - Pop on `tx_valid && tx_ready`.
  - A push when full and not popping that cycle is dropped and sets tx_overflow.
  - Push and pop in the same cycle are both honoured; count is unchanged, including when full.
  - A STATUS read clears tx_overflow. If an overflow event happens on the same edge, set wins.
- RX:
  - `rx_ready` = !rx_held.
  - Capture `rx_data` on `rx_valid && rx_ready`.
  - An RXDATA read and an `rx_valid` arriving in the same cycle: no capture (ready=0), the read clears rx_held, and the byte is captured the next cycle if still valid.
- Reset values:
  - `led`=0.
  - TX FIFO empty: `tx_valid`=0, `tx_data`=0.
  - rx_held=0, `rx_ready`=1.
  - tx_overflow=0.
  - CYCLES=0.
- RAM contents are not reset. Reset mid-operation discards FIFO contents and held byte immediately (asynchronous).

## Timing
- Load latency 0: `data_mem_out` is valid in the same cycle as `memread`, so the CPU latches it into MEM/WB at the next edge. No stall or handshake on the CPU side.
- Store visible to a load issued in the following cycle.
- TXDATA push appears on `tx_valid` and `tx_data` one cycle after the store edge.
- Captured RX byte is visible in STATUS bit2 and RXDATA one cycle after the capture edge.
- CYCLES read returns the value held during the load cycle.

## Structure
- Shared package holds:
  - Address-map constants: `MMIO_BASE`, LED/TXDATA/STATUS/RXDATA/CYCLES offsets.
  - STATUS bit indices.
- Sub-module `byte_fifo`: parameterised depth; push, pop, full, empty, head. Used for TX.
- RAM is a register array with asynchronous read and synchronous write, inferred in this module.

## Test plan
- Store `0xDEADBEEF` to `0x0000_0010`, then load `0x0000_0010` next cycle -> `data_mem_out`=`0xDEADBEEF`. Load `0x0000_1000` with `WORDS`=1024 -> 0.
- Store `0xA5` to LED -> `led`=`0xA5` after the edge. Assert `rst_n`=0 mid-cycle -> `led`=0 immediately.
- With `tx_ready`=0, push bytes `0x01`..`0x05` -> STATUS reads `0x9` (full, overflow) and holds `0x01`..`0x04`. A second STATUS read -> `0x1`. Raise `tx_ready` -> `0x01`..`0x04` emitted in order, then `tx_valid`=0.
- FIFO full, `tx_ready`=1, push `0x77` in the same cycle -> no overflow, `0x77` emitted fifth.
- Drive `rx_valid` with `0x3C` -> `rx_ready`=0, STATUS bit2=1. RXDATA read -> `0x3C`, `rx_ready`=1 next cycle. Second RXDATA read -> 0.
- Release reset, then load CYCLES 10 cycles later -> 10. Preload the counter to `0xFFFF_FFFF` via force -> reads 0 next cycle.
